// File: rtl/interface_wb_pkg.sv
// interface_wb_pkg: shared FSM state type, lane count and default lane width
package interface_wb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int LANES = 4;
  localparam int DEF_DW = 64;
endpackage

// File: rtl/interface_wb_permw.sv
// interface_wb_permw: combinational inverse lane rotation, q[(i+sel)%4] = d[i]
module interface_wb_permw #(
  parameter int DW = 64
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [DW-1:0] q0,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic [DW-1:0] q3
);
  assign q0 = sel == 2'd0 ? d0 : sel == 2'd1 ? d3 : sel == 2'd2 ? d2 : d1;
  assign q1 = sel == 2'd0 ? d1 : sel == 2'd1 ? d0 : sel == 2'd2 ? d3 : d2;
  assign q2 = sel == 2'd0 ? d2 : sel == 2'd1 ? d1 : sel == 2'd2 ? d0 : d3;
  assign q3 = sel == 2'd0 ? d3 : sel == 2'd1 ? d2 : sel == 2'd2 ? d1 : d0;
endmodule

// File: rtl/interface_wb.sv
// interface_wb: frame writer that rotates four lanes per beat into IOBUF or FSC banks.
// Optional sticky ERR output for beats arriving outside a frame: define INTERFACE_WB_ERR_EN.
module interface_wb
  import interface_wb_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DW = DEF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sel_itr,
  input  logic              valid_in,
  input  logic [DW-1:0]     d0,
  input  logic [DW-1:0]     d1,
  input  logic [DW-1:0]     d2,
  input  logic [DW-1:0]     d3,
  output logic [DW-1:0]     q0,
  output logic [DW-1:0]     q1,
  output logic [DW-1:0]     q2,
  output logic [DW-1:0]     q3,
  output logic [ADDR_W-1:0] addr,
  output logic              we_iobuf,
  output logic              we_fsc,
  output logic              busy,
  output logic              done
`ifdef INTERFACE_WB_ERR_EN
  ,
  output logic              err
`endif
);
  localparam int ND = (ADDR_W + 1) / 2;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt;
  logic dst;
  logic [2*ND-1:0] cnt_p;
  logic [$clog2(LANES)-1:0] sel;
  logic [DW-1:0] p0, p1, p2, p3;
  logic go, acc, last;
  assign go = state_q == IDLE && start;
  assign acc = state_q == RUN && valid_in;
  assign last = acc && &cnt;
  assign busy = state_q != IDLE;
  assign cnt_p = (2*ND)'(cnt);
  // Rotation amount: sum of the beat counter's 2-bit digits, wrapping mod 4
  always_comb begin
    sel = '0;
    for (int i = 0; i < ND; i++) sel = sel + cnt_p[2*i +: 2];
  end
  interface_wb_permw #(.DW(DW)) u_permw (
    .sel(sel), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .q0(p0), .q1(p1), .q2(p2), .q3(p3)
  );
  // Next state: DRAIN is the single cycle carrying the last write and DONE
  always_comb state_d = go ? RUN : last ? DRAIN : state_q == DRAIN ? IDLE : state_q;
  // State register, beat counter and destination latched at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt <= '0;
      dst <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        cnt <= '0;
        dst <= sel_itr;
      end else if (acc) cnt <= cnt + 1'b1;
    end
  end
  // Output register: data/address hold between accepted beats, strobes pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {q0, q1, q2, q3} <= '0;
      addr <= '0;
      we_iobuf <= 1'b0;
      we_fsc <= 1'b0;
      done <= 1'b0;
    end else begin
      if (acc) begin
        {q0, q1, q2, q3} <= {p0, p1, p2, p3};
        addr <= cnt;
      end
      we_iobuf <= acc && !dst;
      we_fsc <= acc && dst;
      done <= last;
    end
  end
`ifdef INTERFACE_WB_ERR_EN
  // Sticky flag for beats offered while no frame is accepting them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (valid_in && state_q != RUN) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_interface_wb.sv
// tb_interface_wb: directed and randomized checks of interface_wb against a frame-level model
module tb_interface_wb;
  localparam int AW = 6;
  localparam int N = 1 << AW;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, sel_itr = 1'b0, valid_in = 1'b0;
  logic [63:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [63:0] q0, q1, q2, q3;
  logic [AW-1:0] addr;
  logic we_iobuf, we_fsc, busy, done;
`ifdef INTERFACE_WB_ERR_EN
  logic err;
`endif
  interface_wb #(.ADDR_W(AW), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_itr(sel_itr), .valid_in(valid_in),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .addr(addr), .we_iobuf(we_iobuf), .we_fsc(we_fsc), .busy(busy), .done(done)
`ifdef INTERFACE_WB_ERR_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] a;
    logic [3:0][63:0] q;
  } rvec_t;

  int n_vec = 0, n_err = 0;
  int n_fsc, n_iob, n_done;
  bit m_active = 0, m_drain = 0, m_dst = 0;
  int m_beats = 0;
  logic [63:0] e_q[4];
  logic [AW-1:0] e_addr = '0;
  bit e_iob = 0, e_fsc = 0, e_done = 0, e_busy = 0, e_err = 0;
  logic [3:0][63:0] cap[N];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int dsum(input int x);
    int s = 0;
    while (x > 0) begin
      s += x % 4;
      x /= 4;
    end
    return s % 4;
  endfunction

  task automatic step(input bit s, input bit sl, input bit v,
                      input logic [63:0] x0, input logic [63:0] x1,
                      input logic [63:0] x2, input logic [63:0] x3);
    logic [63:0] din[4];
    bit acc;
    int r;
    din = '{x0, x1, x2, x3};
    start = s; sel_itr = sl; valid_in = v;
    d0 = x0; d1 = x1; d2 = x2; d3 = x3;
    acc = m_active && v;
    e_iob = acc && !m_dst;
    e_fsc = acc && m_dst;
    e_done = acc && m_beats == N - 1;
    if (acc) begin
      r = dsum(m_beats);
      for (int i = 0; i < 4; i++) e_q[(i + r) % 4] = din[i];
      e_addr = AW'(m_beats);
    end
    if (v && !m_active) e_err = 1;
    if (m_drain) m_drain = 0;
    else if (!m_active && s) begin
      m_active = 1; m_beats = 0; m_dst = sl;
    end else if (acc) begin
      m_beats++;
      if (m_beats == N) begin
        m_active = 0; m_drain = 1;
      end
    end
    e_busy = m_active || m_drain;
    @(posedge clk);
    #1;
    chk("we_iobuf", 256'(we_iobuf), 256'(e_iob));
    chk("we_fsc", 256'(we_fsc), 256'(e_fsc));
    chk("done", 256'(done), 256'(e_done));
    chk("busy", 256'(busy), 256'(e_busy));
    chk("addr", 256'(addr), 256'(e_addr));
    chk("q", {q3, q2, q1, q0}, {e_q[3], e_q[2], e_q[1], e_q[0]});
`ifdef INTERFACE_WB_ERR_EN
    chk("err", 256'(err), 256'(e_err));
`endif
    if (we_iobuf || we_fsc) cap[addr] = {q3, q2, q1, q0};
    n_fsc += int'(we_fsc);
    n_iob += int'(we_iobuf);
    n_done += int'(done);
  endtask

  task automatic do_reset();
    start = 0; valid_in = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_we", 256'({we_iobuf, we_fsc}), 256'(0));
    chk("rst_done_busy", 256'({done, busy}), 256'(0));
    chk("rst_addr", 256'(addr), 256'(0));
    chk("rst_q", {q3, q2, q1, q0}, 256'(0));
`ifdef INTERFACE_WB_ERR_EN
    chk("rst_err", 256'(err), 256'(0));
`endif
    m_active = 0; m_drain = 0; m_dst = 0; m_beats = 0;
    e_iob = 0; e_fsc = 0; e_done = 0; e_busy = 0; e_err = 0; e_addr = '0;
    for (int i = 0; i < 4; i++) e_q[i] = '0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] pat(input int k, input int i);
    return 64'(k * 256 + i);
  endfunction

  initial begin
    rvec_t tv[7];
    int r;
    logic [63:0] back;
    tv[0] = {6'd0,  64'h3,    64'h2,    64'h1,    64'h0};
    tv[1] = {6'd1,  64'h102,  64'h101,  64'h100,  64'h103};
    tv[2] = {6'd5,  64'h501,  64'h500,  64'h503,  64'h502};
    tv[3] = {6'd6,  64'h600,  64'h603,  64'h602,  64'h601};
    tv[4] = {6'd7,  64'h703,  64'h702,  64'h701,  64'h700};
    tv[5] = {6'd42, 64'h2A01, 64'h2A00, 64'h2A03, 64'h2A02};
    tv[6] = {6'd63, 64'h3F02, 64'h3F01, 64'h3F00, 64'h3F03};
    for (int i = 0; i < 4; i++) e_q[i] = '0;
    do_reset();

    // FSC frame, valid toggling, START pulses and SEL_ITR flips mid-frame and in DRAIN
    n_fsc = 0; n_iob = 0; n_done = 0;
    step(1, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 300 && (m_active || m_drain); c++)
      step(c % 7 == 3 || m_drain, c[0], c % 2 == 0,
           pat(m_beats, 0), pat(m_beats, 1), pat(m_beats, 2), pat(m_beats, 3));
    chk("fsc_pulses", 256'(n_fsc), 256'(N));
    chk("iobuf_pulses", 256'(n_iob), 256'(0));
    chk("done_pulses", 256'(n_done), 256'(1));
    for (int k = 0; k < 7; k++) begin
      chk("rot_table", cap[tv[k].a], tv[k].q);
      r = dsum(int'(tv[k].a));
      for (int i = 0; i < 4; i++) begin
        back = cap[tv[k].a][(i + r) % 4];
        chk("readback", 256'(back), 256'(pat(int'(tv[k].a), i)));
      end
    end

    // beats offered in IDLE are dropped
    for (int c = 0; c < 3; c++) step(0, 0, 1, 64'hDEAD, 64'hBEEF, 64'hCAFE, 64'hF00D);

    // reset after 10 accepted beats of an IOBUF frame, then restart at address 0
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 1, 1, pat(c, 0), pat(c, 1), pat(c, 2), pat(c, 3));
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 64'h11, 64'h22, 64'h33, 64'h44);
    chk("restart_addr", 256'(addr), 256'(0));
    chk("restart_we", 256'({we_iobuf, we_fsc}), 256'(2'b10));

    // randomized traffic
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
           {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/interface_wb.md
INTERFACE_WB -- requirements
Module: interface_wb

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set beat-address width; frame length = 2**ADDR_W beats.
REQ-002 Parameter DW, default 64, SHALL set lane data width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 RSTN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 START  input  1  SHALL request a new frame; sampled only in IDLE.
REQ-006 SEL_ITR  input  1  SHALL select the destination, latched at START: 0 = IOBUF, 1 = FSC.
REQ-007 VALID_IN  input  1  SHALL qualify one beat on D0..D3.
REQ-008 D0, D1, D2, D3  input  DW each  SHALL carry the four processed lanes of one beat.
REQ-009 Q0, Q1, Q2, Q3  output  DW each  SHALL carry the registered, inverse-permuted bank write data.
REQ-010 ADDR  output  ADDR_W  SHALL carry the registered bank write address.
REQ-011 WE_IOBUF, WE_FSC  output  1 each  SHALL be the registered write enables; at most one is high.
REQ-012 BUSY  output  1  SHALL be high outside IDLE.
REQ-013 DONE  output  1  SHALL pulse for one cycle, coincident with the last write enable of a frame.
REQ-014 ERR  output  1  SHALL exist only under INTERFACE_WB_ERR_EN (REQ-031).

Function
REQ-015 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-016 IDLE -> RUN SHALL occur on START=1; this clears the beat counter CNT and latches SEL_ITR into DST.
REQ-017 In RUN, a beat SHALL be accepted on every cycle with VALID_IN=1, and CNT SHALL increment by 1 modulo 2**ADDR_W.
REQ-018 The rotation SEL SHALL be the sum of CNT's 2-bit digits modulo 4; an odd ADDR_W SHALL use a zero-padded top digit.
REQ-019 Inverse permutation SHALL be Q[(i+SEL) mod 4] = D[i]; for SEL=1, Q0..Q3 = D3,D0,D1,D2.
REQ-020 An accepted beat SHALL appear on Q, ADDR=CNT, and WE_<DST> exactly 1 cycle later; latency is fixed at 1.
REQ-021 On cycles with no accepted beat, WE_IOBUF and WE_FSC SHALL be 0 and Q/ADDR SHALL hold their previous values.
REQ-022 Acceptance of the beat with CNT = 2**ADDR_W-1 SHALL move RUN -> DRAIN, wrapping CNT to 0.
REQ-023 DRAIN SHALL last exactly one cycle, assert DONE together with the final WE, then enter IDLE.
REQ-024 VALID_IN in IDLE or DRAIN SHALL be ignored, with no write and no CNT change.
REQ-025 START outside IDLE SHALL be ignored.
REQ-026 START in the DRAIN cycle SHALL be ignored; a new frame SHALL need START in IDLE, giving a minimum 1-cycle gap between frames.
REQ-027 A change of SEL_ITR mid-frame SHALL NOT affect DST.

Reset
REQ-028 RSTN=0 SHALL immediately force state IDLE, CNT=0, DST=0, Q0..Q3=0, ADDR=0, WE_*=0, DONE=0, BUSY=0, and ERR=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no further writes; the next frame SHALL restart at ADDR 0.
REQ-030 Reset deassertion SHALL take effect on the next CLK edge; the first START is accepted at the earliest 1 cycle after deassertion.

Configuration
REQ-031 When INTERFACE_WB_ERR_EN is defined, ERR SHALL become a sticky flag set by VALID_IN=1 in IDLE or DRAIN and cleared only by reset.
REQ-032 When INTERFACE_WB_ERR_EN is undefined, the ERR port SHALL be absent and such beats SHALL be silently dropped.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef, the lane count constant (4), and the default DW.
REQ-034 The lane rotation SHALL be a combinational sub-module PERMW (inputs SEL[1:0] and D0..D3; outputs Q0..Q3), instantiated once ahead of the output register.

Verification
REQ-035 ADDR_W=2; START with SEL_ITR=0; 4 beats with D_i = 0x10*beat + i -> WE_IOBUF high 4 cycles with ADDR 0,1,2,3; SEL 0,1,2,3; DONE on the 4th; WE_FSC never high.
REQ-036 The beat at ADDR=1, with D0..D3 = A,B,C,D -> Q0..Q3 = D,A,B,C; read back through the read-side rotate SHALL restore A,B,C,D.
REQ-037 ADDR_W=6, SEL_ITR=1, VALID_IN toggling 1/0 -> 64 WE_FSC pulses; ADDR 5 (digits 1,1) gives SEL=2; DONE once, 1 cycle after the 64th accept.
REQ-038 Reset asserted after 10 accepted beats -> all outputs 0 asynchronously; a new START gives a first write at ADDR 0.
REQ-039 VALID_IN=1 in IDLE with ERR_EN defined -> no WE and ERR=1 held; with ERR_EN undefined -> no WE.
REQ-040 START pulses during RUN and DRAIN and SEL_ITR flipping mid-frame -> frame length and destination unchanged.
